// File: rtl/load_dcache.sv
// Direct-mapped, read-only data cache serving load queries from the LQ.
// Hits are answered in the cycle after acceptance. A miss is handled by a
// single MSHR that fetches the whole block from memory and answers later.
module load_dcache #(
  parameter int MEM_IDX_W = 32,
  parameter int LQ_IDX_W  = 4,
  parameter int BLK_W     = 64,
  parameter int SETS      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 qry,
  input  logic [MEM_IDX_W-1:0] qry_mem_idx,
  input  logic [LQ_IDX_W-1:0]  qry_lq_idx,
  output logic                 ack,
  output logic [LQ_IDX_W-1:0]  ack_head,
  output logic                 hit,
  output logic [BLK_W-1:0]     hit_blk,
  output logic                 ans,
  output logic [LQ_IDX_W-1:0]  ans_head,
  output logic [BLK_W-1:0]     ans_blk,
  output logic                 mem_req,
  output logic [MEM_IDX_W-1:0] mem_req_idx,
  input  logic                 mem_req_rdy,
  input  logic                 mem_rsp,
  input  logic [BLK_W-1:0]     mem_rsp_blk
);

  localparam int SET_W = $clog2(SETS);
  localparam int TAG_W = MEM_IDX_W - SET_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  state_t state;
  state_t state_next;

  logic [SETS-1:0]      valid;
  logic [TAG_W-1:0]     tag_arr  [SETS];
  logic [BLK_W-1:0]     data_arr [SETS];

  logic [MEM_IDX_W-1:0] mshr_idx;
  logic [LQ_IDX_W-1:0]  mshr_lq;

  logic [SET_W-1:0]     q_set;
  logic [TAG_W-1:0]     q_tag;
  logic [SET_W-1:0]     f_set;
  logic [TAG_W-1:0]     f_tag;
  logic                 lookup_hit;
  logic                 accept;
  logic                 miss_accept;
  logic                 fill;

  assign q_set       = qry_mem_idx[SET_W-1:0];
  assign q_tag       = qry_mem_idx[MEM_IDX_W-1:SET_W];
  assign f_set       = mshr_idx[SET_W-1:0];
  assign f_tag       = mshr_idx[MEM_IDX_W-1:SET_W];

  // Lookup sees the array as it was before any fill landing on this same edge,
  // so a miss sampled on the fill edge is still refused (state is WAIT).
  assign lookup_hit  = valid[q_set] && (tag_arr[q_set] == q_tag);
  assign accept      = qry && (lookup_hit || (state == ST_IDLE));
  assign miss_accept = accept && !lookup_hit;
  assign fill        = (state == ST_WAIT) && mem_rsp;

  assign mem_req     = (state == ST_REQ);
  assign mem_req_idx = mshr_idx;

  // MSHR next-state: start on an accepted miss, hand off on rdy, finish on rsp.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (miss_accept) state_next = ST_REQ;
      ST_REQ:  if (mem_req_rdy) state_next = ST_WAIT;
      ST_WAIT: if (mem_rsp)     state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, valid bits, MSHR capture and registered response pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      valid    <= '0;
      mshr_idx <= '0;
      mshr_lq  <= '0;
      ack      <= 1'b0;
      ack_head <= '0;
      hit      <= 1'b0;
      hit_blk  <= '0;
      ans      <= 1'b0;
      ans_head <= '0;
      ans_blk  <= '0;
    end else begin
      state <= state_next;
      ack   <= accept;
      hit   <= accept && lookup_hit;
      ans   <= fill;
      if (accept) ack_head <= qry_lq_idx;
      if (accept && lookup_hit) hit_blk <= data_arr[q_set];
      if (miss_accept) begin
        mshr_idx <= qry_mem_idx;
        mshr_lq  <= qry_lq_idx;
      end
      if (fill) begin
        valid[f_set] <= 1'b1;
        ans_head     <= mshr_lq;
        ans_blk      <= mem_rsp_blk;
      end
    end
  end

  // Tag and data arrays need no reset; the valid bits guard them.
  always_ff @(posedge clock) begin
    if (fill) begin
      tag_arr[f_set]  <= f_tag;
      data_arr[f_set] <= mem_rsp_blk;
    end
  end

endmodule

// File: tb/tb_load_dcache.sv
// Self-checking bench for load_dcache: expected acks and answers are queued
// when stimulus is driven and checked when the cache produces them.
module tb_load_dcache;

  logic        clock = 1'b0;
  logic        reset;
  logic        qry;
  logic [31:0] qry_mem_idx;
  logic [3:0]  qry_lq_idx;
  logic        ack;
  logic [3:0]  ack_head;
  logic        hit;
  logic [63:0] hit_blk;
  logic        ans;
  logic [3:0]  ans_head;
  logic [63:0] ans_blk;
  logic        mem_req;
  logic [31:0] mem_req_idx;
  logic        mem_req_rdy;
  logic        mem_rsp;
  logic [63:0] mem_rsp_blk;

  load_dcache dut (
    .clock       (clock),
    .reset       (reset),
    .qry         (qry),
    .qry_mem_idx (qry_mem_idx),
    .qry_lq_idx  (qry_lq_idx),
    .ack         (ack),
    .ack_head    (ack_head),
    .hit         (hit),
    .hit_blk     (hit_blk),
    .ans         (ans),
    .ans_head    (ans_head),
    .ans_blk     (ans_blk),
    .mem_req     (mem_req),
    .mem_req_idx (mem_req_idx),
    .mem_req_rdy (mem_req_rdy),
    .mem_rsp     (mem_rsp),
    .mem_rsp_blk (mem_rsp_blk)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  lq;
    logic        h;
    logic [63:0] blk;
  } exp_t;

  exp_t        ack_q[$];
  exp_t        ans_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [63:0] model_hit_blk = '0;
  int          ack_cyc;
  int          fill_cyc;

  localparam logic [63:0] BLK_25 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] BLK_10 = 64'h1010_1010_AAAA_0010;
  localparam logic [63:0] BLK_31 = 64'h3131_3131_BBBB_0031;
  localparam logic [63:0] BLK_05 = 64'h0505_0505_CCCC_0005;
  localparam logic [63:0] BLK_15 = 64'h1515_1515_DDDD_0015;
  localparam logic [63:0] BLK_50 = 64'h5050_5050_EEEE_0050;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every ack/ans pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && ack) begin
      if (ack_q.size() == 0) begin
        checkOutput("ack_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = ack_q.pop_front();
        checkOutput("ack_head", ack_head, e.lq);
        checkOutput("hit", hit, e.h);
        if (e.h) model_hit_blk = e.blk;
        checkOutput("hit_blk", hit_blk, model_hit_blk);
      end
    end
    if (!reset && ans) begin
      if (ans_q.size() == 0) begin
        checkOutput("ans_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = ans_q.pop_front();
        checkOutput("ans_head", ans_head, e.lq);
        checkOutput("ans_blk", ans_blk, e.blk);
      end
    end
  end

  // Hold a query until acked; reports the cycle in which ack was seen.
  task automatic applyStimulus(input logic [31:0] idx, input logic [3:0] lq,
                               input logic exp_hit, input logic [63:0] exp_blk,
                               output int seen_cyc);
    exp_t e;
    bit   got;
    e.lq = lq; e.h = exp_hit; e.blk = exp_blk;
    ack_q.push_back(e);
    qry_mem_idx = idx;
    qry_lq_idx  = lq;
    qry         = 1'b1;
    got         = 1'b0;
    seen_cyc    = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clock); #1;
      if (ack) begin
        got      = 1'b1;
        seen_cyc = cyc;
      end
    end
    qry = 1'b0;
    if (!got) begin
      checkOutput("ack_timeout", 0, 1);
      void'(ack_q.pop_back());
    end
  endtask

  // Wait for the memory request, check it, stall it, then accept it.
  task automatic mem_handshake(input logic [31:0] exp_idx, input int stall);
    for (int i = 0; i < 40 && !mem_req; i++) begin
      @(posedge clock); #1;
    end
    checkOutput("mem_req_seen", mem_req, 1);
    checkOutput("mem_req_idx", mem_req_idx, exp_idx);
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      checkOutput("mem_req_held", mem_req, 1);
      checkOutput("mem_req_idx_held", mem_req_idx, exp_idx);
    end
    mem_req_rdy = 1'b1;
    @(posedge clock); #1;
    mem_req_rdy = 1'b0;
    checkOutput("mem_req_drop", mem_req, 0);
  endtask

  task automatic mem_respond(input logic [63:0] blk, input logic [3:0] lq, output int edge_cyc);
    exp_t e;
    e.lq = lq; e.h = 1'b0; e.blk = blk;
    ans_q.push_back(e);
    mem_rsp_blk = blk;
    mem_rsp     = 1'b1;
    @(posedge clock); #1;
    edge_cyc = cyc;
    mem_rsp  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    qry         = 1'b0;
    qry_mem_idx = '0;
    qry_lq_idx  = '0;
    mem_req_rdy = 1'b0;
    mem_rsp     = 1'b0;
    mem_rsp_blk = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_hit", hit, 0);
    checkOutput("rst_ans", ans, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_req_idx", mem_req_idx, 0);
    checkOutput("rst_hit_blk", hit_blk, 0);
    checkOutput("rst_ans_blk", ans_blk, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Cold miss, stalled request, fill and deferred answer.
    applyStimulus(32'h25, 4'd3, 1'b0, '0, ack_cyc);
    mem_handshake(32'h25, 2);
    mem_respond(BLK_25, 4'd3, fill_cyc);
    @(posedge clock); #1;

    // Hit on the filled block, no memory traffic.
    applyStimulus(32'h25, 4'd7, 1'b1, BLK_25, ack_cyc);
    checkOutput("hit_no_mem_req", mem_req, 0);

    // Hit under miss, then a second miss blocked until the fill edge passes.
    applyStimulus(32'h10, 4'd1, 1'b0, '0, ack_cyc);
    mem_handshake(32'h10, 0);
    applyStimulus(32'h25, 4'd2, 1'b1, BLK_25, ack_cyc);
    fork
      applyStimulus(32'h31, 4'd4, 1'b0, '0, ack_cyc);
      begin
        repeat (3) begin
          @(posedge clock); #1;
          checkOutput("blocked_no_ack", ack, 0);
        end
        mem_respond(BLK_10, 4'd1, fill_cyc);
      end
    join
    checkOutput("race_ack_cyc", ack_cyc, fill_cyc + 1);
    mem_handshake(32'h31, 1);
    applyStimulus(32'h10, 4'd11, 1'b1, BLK_10, ack_cyc);
    mem_respond(BLK_31, 4'd4, fill_cyc);
    @(posedge clock); #1;
    applyStimulus(32'h31, 4'd12, 1'b1, BLK_31, ack_cyc);

    // Conflict in one set evicts the earlier line.
    applyStimulus(32'h05, 4'd5, 1'b0, '0, ack_cyc);
    mem_handshake(32'h05, 0);
    mem_respond(BLK_05, 4'd5, fill_cyc);
    applyStimulus(32'h15, 4'd6, 1'b0, '0, ack_cyc);
    mem_handshake(32'h15, 0);
    mem_respond(BLK_15, 4'd6, fill_cyc);
    applyStimulus(32'h05, 4'd8, 1'b0, '0, ack_cyc);
    mem_handshake(32'h05, 0);
    mem_respond(BLK_05, 4'd8, fill_cyc);
    @(posedge clock); #1;
    applyStimulus(32'h05, 4'd13, 1'b1, BLK_05, ack_cyc);

    // Reset while waiting for memory drops the miss; a late rsp is ignored.
    applyStimulus(32'h50, 4'd9, 1'b0, '0, ack_cyc);
    mem_handshake(32'h50, 0);
    reset = 1'b1;
    #2;
    checkOutput("midrst_mem_req", mem_req, 0);
    checkOutput("midrst_ans", ans, 0);
    model_hit_blk = '0;
    @(posedge clock); #1;
    reset       = 1'b0;
    mem_rsp_blk = BLK_50;
    mem_rsp     = 1'b1;
    @(posedge clock); #1;
    mem_rsp     = 1'b0;
    @(posedge clock); #1;
    checkOutput("late_rsp_no_ans", ans, 0);
    applyStimulus(32'h50, 4'd10, 1'b0, '0, ack_cyc);
    mem_handshake(32'h50, 0);
    mem_respond(BLK_50, 4'd10, fill_cyc);
    repeat (3) @(posedge clock);
    #1;

    checkOutput("ack_q_drained", ack_q.size(), 0);
    checkOutput("ans_q_drained", ans_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_dcache.md
Name: load_dcache

Overview:
- Direct-mapped, read-only data cache that answers load queries issued by the load queue (LQ).
- Implements the data-store side of the load query interface:
  - qry/ack handshake;
  - same-pipeline-cycle hit return;
  - deferred miss answer.
- Has a single-outstanding miss handler (one MSHR) that fetches whole blocks from memory over a req/rsp channel.
- Sits directly downstream of the LQ and upstream of the memory port.

Parameters:
- MEM_IDX_W, 32, width of block-granular memory index (qry_mem_idx, mem_req_idx).
- LQ_IDX_W, 4, width of LQ entry index (qry_lq_idx, ack_head, ans_head).
- BLK_W, 64, width of one memory block.
- SETS, 16, number of cache lines; power of two, >=2. SET_W = log2(SETS), TAG_W = MEM_IDX_W - SET_W.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- qry  in  1  LQ presents a load query; held until ack.
- qry_mem_idx  in  MEM_IDX_W  block index to load.
- qry_lq_idx  in  LQ_IDX_W  issuing LQ entry.
- ack  out  1  query accepted (registered pulse).
- ack_head  out  LQ_IDX_W  LQ index of the accepted query.
- hit  out  1  accepted query hit; valid only with ack.
- hit_blk  out  BLK_W  hit data.
- ans  out  1  deferred miss answer (registered pulse).
- ans_head  out  LQ_IDX_W  LQ index being answered.
- ans_blk  out  BLK_W  block returned for the miss.
- mem_req  out  1  memory read request.
- mem_req_idx  out  MEM_IDX_W  block index requested.
- mem_req_rdy  in  1  memory accepts the request this cycle.
- mem_rsp  in  1  memory returns block.
- mem_rsp_blk  in  BLK_W  returned block.

Behaviour:
- Storage and reset
  - Per line: valid bit, TAG_W tag, BLK_W data.
  - set = qry_mem_idx[SET_W-1:0]; tag = upper TAG_W bits.
  - Reset clears all valid bits, MSHR state -> IDLE, and all outputs to 0 (ack, hit, ans, mem_req, heads, blks, mem_req_idx).
  - Data array contents are don't-care after reset.
- Query acceptance
  - Evaluated at each rising edge while qry=1.
  - lookup_hit = valid[set] && tag match.
  - Accept if lookup_hit, or if (!lookup_hit && state==IDLE).
  - Otherwise no ack; the LQ keeps qry asserted and retries.
- Response timing
  - Query accepted at edge N -> cycle N+1: ack=1, ack_head=qry_lq_idx.
  - On a hit, also in cycle N+1: hit=1, hit_blk=data[set].
  - On a miss, in cycle N+1: hit=0 and hit_blk holds its previous value. The MSHR captures mem_idx and lq_idx, and state -> REQ.
  - ack, hit and ans are single-cycle pulses. Back-to-back accepted queries give consecutive ack pulses.
- MSHR state machine
  - IDLE: mem_req=0.
  - REQ: mem_req=1, mem_req_idx=MSHR idx, held stable. mem_req && mem_req_rdy at an edge -> WAIT.
  - WAIT: mem_rsp=1 at edge M -> write the line (valid=1, tag, data = mem_rsp_blk) at edge M; cycle M+1: ans=1, ans_head=MSHR lq_idx, ans_blk=mem_rsp_blk; state -> IDLE at edge M.
  - mem_rsp outside WAIT is ignored, including after a mid-operation reset.
- Hits under miss
  - Allowed in REQ/WAIT, including hits to the set being refilled (old line, if its tag matches).
  - A query sampled at edge M (the fill edge) that misses is not accepted, because state is still WAIT at sampling. It is accepted at edge M+1.
  - A query at edge M+1 for the filled block hits.
- Simultaneous events
  - ack and ans may pulse in the same cycle.
  - A fill overwrites the existing line in that set regardless of its prior validity (direct-mapped replacement).
- Reset mid-operation
  - Async reset takes effect immediately: outstanding miss dropped, no ans issued, mem_req deasserted.

Test Plan:
- After reset, qry=1, mem_idx=0x25, lq=3 -> cycle+1: ack=1, ack_head=3, hit=0; mem_req=1, mem_req_idx=0x25. Hold mem_req_rdy=0 two cycles -> mem_req remains 1. Raise rdy, then mem_rsp with blk=0xDEAD_BEEF_0000_0001 -> next cycle ans=1, ans_head=3, ans_blk=0xDEAD_BEEF_0000_0001.
- After that fill, qry mem_idx=0x25, lq=7 -> ack=1, ack_head=7, hit=1, hit_blk=0xDEAD_BEEF_0000_0001; no mem_req.
- Miss on 0x10 outstanding (WAIT). Query 0x25 (hit) -> acked with hit. Query 0x31 (miss) -> no ack until the cycle after ans for 0x10, then ack=1, hit=0, mem_req_idx=0x31.
- Conflict: fill 0x05 then 0x15 (same set, SETS=16) -> a subsequent qry 0x05 misses with ack=1, hit=0, mem_req_idx=0x05.
- Assert reset while in WAIT, then drive mem_rsp=1 -> no ans, line not written; qry for the same idx misses.
- Fill-edge race: qry miss 0x40 held while mem_rsp arrives for 0x20 at edge M -> ack for 0x40 occurs in cycle M+2, not M+1. A qry for 0x20 at edge M+1 hits.
